// File: rtl/fx_accum_pkg.sv
// fx_accum_pkg: shared types and constants for the fx_accum accumulator.
//   state_e        : accumulator FSM states
//   ADD_LAT_DEF    : default fp_add latency in cycles
//   FIFO_DEPTH_DEF : default input buffer depth
//   FP_ZERO        : IEEE-754 single-precision +0.0
package fx_accum_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ADDING = 2'd2
  } state_e;

  localparam int          ADD_LAT_DEF    = 2;
  localparam int          FIFO_DEPTH_DEF = 2;
  localparam logic [31:0] FP_ZERO        = 32'h0000_0000;

endpackage

// File: rtl/fp_add.sv
// fp_add: single-precision floating-point adder with fixed latency.
//   clk, areset (async, active high), en (pipeline advance enable)
//   a, b : operands; q : a + b
// Operands held stable for LAT cycles produce their sum on q in the last of
// those cycles (LAT-1 register stages behind a combinational adder).
// Denormals are treated as zero; the result is truncated, not rounded.
module fp_add #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        en,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] q
);

  logic        sx, sy;
  logic [7:0]  ex, ey, dexp;
  logic [23:0] mx, my;
  logic [26:0] xg, yg, norm;
  logic [27:0] s;
  logic [4:0]  lead, sh;
  logic [31:0] sum_c;
  logic [3:0]  unused_bits;

  always_comb begin
    // x is always the operand with the larger magnitude
    if (a[30:0] >= b[30:0]) begin
      sx = a[31]; ex = a[30:23]; mx = (a[30:23] == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
      sy = b[31]; ey = b[30:23]; my = (b[30:23] == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
    end else begin
      sx = b[31]; ex = b[30:23]; mx = (b[30:23] == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
      sy = a[31]; ey = a[30:23]; my = (a[30:23] == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
    end
    dexp = ex - ey;
    xg   = {mx, 3'b000};
    yg   = (dexp > 8'd26) ? 27'd0 : ({my, 3'b000} >> dexp);
    if (sx == sy) s = {1'b0, xg} + {1'b0, yg};
    else          s = {1'b0, xg} - {1'b0, yg};
    lead = 5'd0;
    for (int i = 0; i < 27; i++) if (s[i]) lead = 5'(i);
    sh   = 5'd26 - lead;
    norm = s[26:0] << sh;
    sum_c = 32'd0;
    if (s[27]) begin
      if (ex >= 8'd254) sum_c = {sx, 8'hFF, 23'd0};
      else              sum_c = {sx, ex + 8'd1, s[26:4]};
    end else if (s[26:0] != 27'd0 && ex > {3'b000, sh}) begin
      sum_c = {sx, ex - {3'b000, sh}, norm[25:3]};
    end
    unused_bits = {norm[26], norm[2:0]};
  end

  generate
    if (LAT <= 1) begin : g_comb
      assign q = sum_c;
    end else begin : g_pipe
      logic [LAT-2:0][31:0] pipe_q, pipe_d;
      always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = sum_c;
        for (int i = 1; i < LAT - 1; i++) pipe_d[i] = pipe_q[i-1];
      end
      always_ff @(posedge clk or posedge areset) begin
        if (areset)  pipe_q <= '0;
        else if (en) pipe_q <= pipe_d;
      end
      assign q = pipe_q[LAT-2];
    end
  endgenerate

endmodule

// File: rtl/fx_accum_fifo.sv
// fx_accum_fifo: small circular term buffer for fx_accum.
//   clk, reset (sync, active low), en (hold all state when low)
//   flush : empty the buffer (overrides push/pop)
//   push/wdata : write request; accepted when not full, or full with a pop
//   pop/rdata  : rdata is the head; pop removes it when not empty
//   full, empty : occupancy flags
module fx_accum_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (en) begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (en) mem_q <= mem_d;
  end

endmodule

// File: rtl/fx_accum.sv
// fx_accum: accumulates n single-precision terms streamed from an fx unit.
//   clk, reset (sync, active low), clk_en (global hold when low)
//   start/n        : begin an accumulation of n terms (n=0 completes at once)
//   in_valid/in_data : incoming terms, buffered in a small FIFO
//   busy     : FSM not IDLE
//   done     : one-cycle pulse with a valid sum
//   sum      : result, held until the next completion
//   overflow : sticky, a term was dropped because the buffer was full
module fx_accum
  import fx_accum_pkg::*;
#(
  parameter int ADD_LAT    = ADD_LAT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [15:0] n,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] sum,
  output logic        overflow
);

  localparam int CNT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

  state_e             state_q, state_d;
  logic [15:0]        remaining_q, remaining_d;
  logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic [31:0]        acc_q, acc_d, b_reg_q, b_reg_d, sum_q, sum_d;
  logic               done_q, done_d, overflow_q, overflow_d;

  logic               fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [31:0]        fifo_rdata, add_q;

  fx_accum_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .en    (clk_en),
    .flush (fifo_flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (in_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Operands come straight from acc/b_reg, which stay put for the whole
  // ADDING window, so only one addition is ever in flight.
  fp_add #(.LAT(ADD_LAT)) u_add (
    .clk    (clk),
    .areset (~reset),
    .en     (clk_en),
    .a      (acc_q),
    .b      (b_reg_q),
    .q      (add_q)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    cycle_cnt_d = cycle_cnt_q;
    acc_d       = acc_q;
    b_reg_d     = b_reg_q;
    sum_d       = sum_q;
    done_d      = 1'b0;
    overflow_d  = overflow_q;
    fifo_pop    = 1'b0;
    fifo_flush  = 1'b0;
    fifo_push   = in_valid && (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (n == 16'd0) begin
            done_d = 1'b1;
            sum_d  = FP_ZERO;
          end else begin
            remaining_d = n;
            acc_d       = FP_ZERO;
            overflow_d  = 1'b0;
            state_d     = WAIT;
          end
        end
      end
      WAIT: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          b_reg_d     = fifo_rdata;
          cycle_cnt_d = '0;
          state_d     = ADDING;
        end
      end
      ADDING: begin
        if (cycle_cnt_q == CNT_W'(ADD_LAT - 1)) begin
          acc_d       = add_q;
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) begin
            sum_d      = add_q;
            done_d     = 1'b1;
            state_d    = IDLE;
            fifo_flush = 1'b1;  // leftover terms belong to no accumulation
          end else begin
            state_d = WAIT;
          end
        end else begin
          cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A full buffer still accepts a term when the head leaves this cycle.
    if (fifo_push && fifo_full && !fifo_pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      cycle_cnt_q <= '0;
      acc_q       <= FP_ZERO;
      b_reg_q     <= FP_ZERO;
      sum_q       <= FP_ZERO;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (clk_en) begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      cycle_cnt_q <= cycle_cnt_d;
      acc_q       <= acc_d;
      b_reg_q     <= b_reg_d;
      sum_q       <= sum_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign sum      = sum_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_fx_accum.sv
module tb_fx_accum;
  localparam int ADD_LAT    = 2;
  localparam int FIFO_DEPTH = 2;

  logic        clk = 1'b0, reset = 1'b0, clk_en = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic [15:0] n = 16'd0;
  logic [31:0] in_data = 32'd0;
  logic        busy, done, overflow;
  logic [31:0] sum;

  int tests = 0, fails = 0, cyc = 0;

  typedef struct {
    logic [31:0] sum;
    logic        ovf;
    int          cyc;   // required done cycle, -1 when not checked
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  fx_accum #(.ADD_LAT(ADD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .n(n),
    .in_valid(in_valid), .in_data(in_data), .busy(busy), .done(done),
    .sum(sum), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Exact values only (small multiples of 0.5), so IEEE encoding is a
  // straight re-bias of the double-precision fields.
  function automatic logic [31:0] to_fp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic do_start(input int nn);
    start = 1'b1; n = 16'(nn);
    step();
    start = 1'b0;
  endtask

  task automatic send(input real v, output int p);
    in_valid = 1'b1; in_data = to_fp(v); p = cyc;
    step();
    in_valid = 1'b0;
  endtask

  task automatic expect_sum(input real v, input logic ovf, input int c);
    exp_t e;
    e.sum = to_fp(v); e.ovf = ovf; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && sb.size() > 0; i++) step();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d results still pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, required no pulse", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("sum", sum, mon_e.sum);
        check("overflow", {31'd0, overflow}, {31'd0, mon_e.ovf});
        if (mon_e.cyc >= 0) check("done_cycle", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    int p, nn, gap, k;
    real v, rs;

    repeat (3) step();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", sum, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    reset = 1'b1;
    step();

    // IDLE ignores in_valid
    send(1.0, p);
    check("idle_ignore_busy", {31'd0, busy}, 32'd0);
    check("idle_ignore_ovf", {31'd0, overflow}, 32'd0);

    // n=2, spaced terms, plus a start while busy that must be ignored
    do_start(2);
    send(1.0, p);
    repeat (4) step();
    do_start(7);
    repeat (5) step();
    send(2.0, p);
    expect_sum(3.0, 1'b0, p + ADD_LAT + 2);
    wait_drain();

    // n=3 with latency check on the last term
    do_start(3);
    send(1.0, p); repeat (10) step();
    send(2.0, p); repeat (10) step();
    send(0.5, p);
    expect_sum(3.5, 1'b0, p + ADD_LAT + 2);
    wait_drain();

    // n=0 completes on the next cycle without becoming busy
    expect_sum(0.0, 1'b0, cyc + 1);
    do_start(0);
    check("n0_busy", {31'd0, busy}, 32'd0);
    wait_drain();

    // overflow: four back-to-back terms, the fourth is dropped
    do_start(4);
    in_valid = 1'b1; in_data = to_fp(1.0);
    repeat (4) step();
    in_valid = 1'b0;
    repeat (20) step();
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    check("ovf_still_busy", {31'd0, busy}, 32'd1);
    send(0.0, p);
    expect_sum(3.0, 1'b1, p + ADD_LAT + 2);
    wait_drain();

    // reset in ADDING aborts with no done pulse
    do_start(3);
    send(1.0, p);
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_sum", sum, 32'd0);
    repeat (10) step();

    // clk_en low for 5 cycles during ADDING delays done by exactly 5
    do_start(2);
    send(1.0, p); repeat (10) step();
    send(2.0, p);
    expect_sum(3.0, 1'b0, p + ADD_LAT + 2 + 5);
    step();
    clk_en = 1'b0;
    repeat (5) step();
    clk_en = 1'b1;
    wait_drain();

    // randomized accumulations against a real-valued reference sum
    for (int t = 0; t < 8; t++) begin
      nn = int'($urandom_range(1, 5));
      rs = 0.0;
      do_start(nn);
      for (int j = 0; j < nn; j++) begin
        k = int'($urandom_range(0, 32)) - 16;
        v = real'(k) * 0.5;
        rs = rs + v;
        send(v, p);
        if (j == nn - 1) expect_sum(rs, 1'b0, p + ADD_LAT + 2);
        gap = int'($urandom_range(ADD_LAT + 2, ADD_LAT + 6));
        repeat (gap) step();
        if (j < nn - 1 && $urandom_range(0, 3) == 0) do_start(int'($urandom_range(0, 7)));
      end
      wait_drain();
    end

    repeat (5) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
